// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and single-cycle flush.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: credit-limited requests, prefetch buffer,
// and redirect handling that drops responses to stale in-flight requests.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDITS = DEPTH[CW:0];

   fetch_state_t state;
   fetch_state_t state_next;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_next;
   logic [CW-1:0] discard;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] pcq_count;
   logic [CW:0]   credit_used;
   logic [31:0]   resp_pc;
   logic          accept;
   logic          drop;
   logic          push;
   logic          pop;
   logic          last_drop;
   logic          unused_pc_lsbs;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;

   assign unused_pc_lsbs = ^redirect_pc[1:0];

   assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
   assign mem_req_valid = !reset && (credit_used < CREDITS);
   assign mem_req_addr = fetch_pc;
   assign accept = mem_req_valid && mem_req_ready;

   assign outstanding_next = outstanding + CW'(accept) - CW'(mem_resp_valid);

   // A response arriving with a redirect is stale and never enters the buffer.
   assign drop = (state == DRAIN) || redirect_valid;
   assign push = mem_resp_valid && !drop;
   assign last_drop = (state == DRAIN) && mem_resp_valid && (discard == CW'(1));

   assign out_valid = !reset && (occupancy != '0);
   assign out_pc = head.pc;
   assign out_instr = head.instr;
   assign pop = out_valid && out_ready;

   assign push_entry = '{pc: resp_pc, instr: mem_resp_data};

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .dout  (head),
      .count (occupancy)
   );

   // Never flushed: discarded requests still need their pc popped.
   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pcq (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (mem_resp_valid),
      .flush (1'b0),
      .din   (fetch_pc),
      .dout  (resp_pc),
      .count (pcq_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         state       <= state_next;
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            discard  <= outstanding_next;
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            end
            if (mem_resp_valid && (state == DRAIN)) begin
               discard <= discard - 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      unique case (1'b1)
         redirect_valid: begin
            state_next = (outstanding_next != '0) ? DRAIN : RUN;
         end
         (!redirect_valid && last_drop): begin
            state_next = RUN;
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   a_outstanding: assert property (@(posedge clk) disable iff (reset)
      outstanding <= CW'(DEPTH));
   a_credit: assert property (@(posedge clk) disable iff (reset)
      credit_used <= CREDITS);
   a_resp: assert property (@(posedge clk) disable iff (reset)
      mem_resp_valid |-> (outstanding != '0));
   a_align: assert property (@(posedge clk) disable iff (reset)
      mem_req_addr[1:0] == 2'b00);
   a_pcq: assert property (@(posedge clk) disable iff (reset)
      pcq_count == outstanding);

endmodule
